// File: rtl/passcode_matcher_if.sv
// Keypad/lock-controller bundle for passcode_matcher: digit strobes, compare request,
// password inputs and the verdict/status outputs.
// The master drives entry and password signals; the slave (the matcher) drives status.
interface passcode_matcher_if #(
  parameter int DIGIT_W = 2,
  parameter int MAX_LEN = 4
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic                       key_valid;
  logic [DIGIT_W-1:0]         key_digit;
  logic                       key_clear;
  logic                       compare;
  logic [MAX_LEN*DIGIT_W-1:0] pw_sys;
  logic [LW-1:0]              pw_length;
  logic [LW-1:0]              num_inputs;
  logic                       overflow;
  logic                       match;
  logic                       mismatch;
  logic                       locked;

  modport master (
    output key_valid, key_digit, key_clear, compare, pw_sys, pw_length,
    input  num_inputs, overflow, match, mismatch, locked
  );

  modport slave (
    input  key_valid, key_digit, key_clear, compare, pw_sys, pw_length,
    output num_inputs, overflow, match, mismatch, locked
  );
endinterface

// File: rtl/passcode_matcher.sv
// Keypad code checker: buffers strobed digits and compares them to the system password.
// Latency: num_inputs/overflow update and match/mismatch pulse one cycle after the input edge.
// No backpressure; inputs are ignored during lockout. Lockout built only with PASSCODE_LOCKOUT_EN.
module passcode_matcher #(
  parameter int DIGIT_W     = 2,
  parameter int MAX_LEN     = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              resetn,
  passcode_matcher_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);

  // Reject configurations that would make the lockout counters meaningless.
  if (MAX_FAILS < 1 || LOCK_CYCLES < 1) begin : g_bad_cfg
    $error("passcode_matcher: MAX_FAILS and LOCK_CYCLES must be at least 1");
  end

  logic [DIGIT_W-1:0] entry_q [MAX_LEN];
  logic [DIGIT_W-1:0] entry_d [MAX_LEN];
  logic [LW-1:0]      num_q, num_d;
  logic               ovf_q, ovf_d;
  logic               match_q, match_d;
  logic               mismatch_q, mismatch_d;
  logic               digits_eq;
  logic               code_ok;
  logic               accept;

`ifdef PASSCODE_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic {
    ST_ENTRY   = 1'b0,
    ST_LOCKOUT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;
`endif

  // Entry is correct only if it is exactly pw_length digits long and every digit agrees.
  always_comb begin
    digits_eq = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < bus.pw_length &&
          entry_q[i] != bus.pw_sys[i*DIGIT_W +: DIGIT_W]) begin
        digits_eq = 1'b0;
      end
    end
    code_ok = !ovf_q &&
              (bus.pw_length >= LW'(1)) &&
              (bus.pw_length <= LW'(MAX_LEN)) &&
              (num_q == bus.pw_length) &&
              digits_eq;
  end

  // Next-state logic: clear beats compare beats digit capture; nothing is accepted while locked.
  always_comb begin
    entry_d    = entry_q;
    num_d      = num_q;
    ovf_d      = ovf_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
`ifdef PASSCODE_LOCKOUT_EN
    state_d    = state_q;
    fail_d     = fail_q;
    timer_d    = timer_q;
    accept     = (state_q == ST_ENTRY);
`else
    accept     = 1'b1;
`endif

    if (accept) begin
      if (bus.key_clear) begin
        num_d = '0;
        ovf_d = 1'b0;
      end else if (bus.compare) begin
        num_d = '0;
        ovf_d = 1'b0;
        if (code_ok) begin
          match_d = 1'b1;
`ifdef PASSCODE_LOCKOUT_EN
          fail_d  = '0;
`endif
        end else begin
          mismatch_d = 1'b1;
`ifdef PASSCODE_LOCKOUT_EN
          if (fail_q == FW'(MAX_FAILS - 1)) begin
            state_d = ST_LOCKOUT;
            fail_d  = '0;
            timer_d = TW'(LOCK_CYCLES);
          end else begin
            fail_d  = fail_q + 1'b1;
          end
`endif
        end
      end else if (bus.key_valid) begin
        if (num_q < LW'(MAX_LEN)) begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (LW'(i) == num_q) begin
              entry_d[i] = bus.key_digit;
            end
          end
          num_d = num_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

`ifdef PASSCODE_LOCKOUT_EN
    // The cycle in which the timer is at 1 is the last locked cycle.
    if (state_q == ST_LOCKOUT) begin
      if (timer_q == TW'(1)) begin
        state_d = ST_ENTRY;
        timer_d = '0;
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end
`endif
  end

  // State registers with synchronous active-low reset; a verdict in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      entry_q    <= '{default: '0};
      num_q      <= '0;
      ovf_q      <= 1'b0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
`ifdef PASSCODE_LOCKOUT_EN
      state_q    <= ST_ENTRY;
      fail_q     <= '0;
      timer_q    <= '0;
`endif
    end else begin
      entry_q    <= entry_d;
      num_q      <= num_d;
      ovf_q      <= ovf_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
`ifdef PASSCODE_LOCKOUT_EN
      state_q    <= state_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
`endif
    end
  end

  assign bus.num_inputs = num_q;
  assign bus.overflow   = ovf_q;
  assign bus.match      = match_q;
  assign bus.mismatch   = mismatch_q;
`ifdef PASSCODE_LOCKOUT_EN
  assign bus.locked     = (state_q == ST_LOCKOUT);
`else
  assign bus.locked     = 1'b0;
`endif
endmodule

// File: tb/tb_passcode_matcher.sv
// Self-checking bench for passcode_matcher: directed vector table, hand-written
// multi-cycle sequences (reset, lockout) and randomized traffic against a queue model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_passcode_matcher;
  localparam int DIGIT_W     = 2;
  localparam int MAX_LEN     = 4;
  localparam int MAX_FAILS   = 3;
  localparam int LOCK_CYCLES = 10;
  localparam int LW          = $clog2(MAX_LEN + 1);
  localparam logic [7:0] PW  = 8'b11_10_01_00;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  passcode_matcher_if #(.DIGIT_W(DIGIT_W), .MAX_LEN(MAX_LEN)) bus ();

  passcode_matcher #(
    .DIGIT_W    (DIGIT_W),
    .MAX_LEN    (MAX_LEN),
    .MAX_FAILS  (MAX_FAILS),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the entry is a queue of digits; lockout is a remaining-cycle count.
  int m_ent[$];
  bit m_ovf;
  int m_fails;
  int m_lock;
  bit e_match;
  bit e_mis;

  function automatic int pw_digit(logic [7:0] pw, int i);
    return int'((pw >> (DIGIT_W * i)) & 8'h3);
  endfunction

  function automatic void model_step(bit kv, int kd, bit kc, bit cmp,
                                     logic [7:0] pw, int plen, bit rst);
    bit ok;
    e_match = 1'b0;
    e_mis   = 1'b0;
    if (rst) begin
      m_ent.delete();
      m_ovf = 0; m_fails = 0; m_lock = 0;
    end else if (m_lock > 0) begin
      m_lock--;
    end else if (kc) begin
      m_ent.delete();
      m_ovf = 0;
    end else if (cmp) begin
      ok = !m_ovf && plen >= 1 && plen <= MAX_LEN && m_ent.size() == plen;
      if (ok)
        for (int i = 0; i < plen; i++)
          if (m_ent[i] != pw_digit(pw, i)) ok = 0;
      m_ent.delete();
      m_ovf = 0;
      if (ok) begin
        e_match = 1'b1;
        m_fails = 0;
      end else begin
        e_mis = 1'b1;
`ifdef PASSCODE_LOCKOUT_EN
        m_fails++;
        if (m_fails == MAX_FAILS) begin
          m_fails = 0;
          m_lock  = LOCK_CYCLES;
        end
`endif
      end
    end else if (kv) begin
      if (m_ent.size() < MAX_LEN) m_ent.push_back(kd);
      else m_ovf = 1;
    end
  endfunction

  task automatic cyc(bit kv, int kd, bit kc, bit cmp, logic [7:0] pw, int plen, bit rst);
    bus.key_valid = kv;
    bus.key_digit = DIGIT_W'(kd);
    bus.key_clear = kc;
    bus.compare   = cmp;
    bus.pw_sys    = pw;
    bus.pw_length = LW'(plen);
    resetn        = !rst;
    model_step(kv, kd, kc, cmp, pw, plen, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int en, bit eo, bit em, bit emm, bit el);
    n_checks++;
    if ({bus.num_inputs, bus.overflow, bus.match, bus.mismatch, bus.locked} ===
        {LW'(en), eo, em, emm, el}) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got num=%0d ovf=%0b match=%0b mismatch=%0b locked=%0b, want num=%0d ovf=%0b match=%0b mismatch=%0b locked=%0b",
               nm, bus.num_inputs, bus.overflow, bus.match, bus.mismatch, bus.locked,
               en, eo, em, emm, el);
    end
  endtask

  task automatic chk_model(string nm);
    chk(nm, m_ent.size(), m_ovf, e_match, e_mis, m_lock > 0);
  endtask

  typedef struct {
    string nm;
    bit    kv;
    int    kd;
    bit    kc;
    bit    cmp;
    int    plen;
    bit    rst;
    int    en;
    bit    eo;
    bit    em;
    bit    emm;
    bit    el;
  } vec_t;

  vec_t tbl[$];

  task automatic add(string nm, bit kv, int kd, bit kc, bit cmp, int plen, bit rst,
                     int en, bit eo, bit em, bit emm);
    vec_t v;
    v.nm = nm; v.kv = kv; v.kd = kd; v.kc = kc; v.cmp = cmp; v.plen = plen; v.rst = rst;
    v.en = en; v.eo = eo; v.em = em; v.emm = emm; v.el = 1'b0;
    tbl.push_back(v);
  endtask

  task automatic add_keys(string nm, int d0, int d1, int d2, int d3, int plen);
    int d[4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) add(nm, 1, d[i], 0, 0, plen, 0, i + 1, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] rpw;
    int         rplen;
    bit         kv, kc, cmp, rst;
    int         kd;

    bus.key_valid = 0; bus.key_digit = '0; bus.key_clear = 0; bus.compare = 0;
    bus.pw_sys = PW; bus.pw_length = LW'(4); resetn = 0;
    @(posedge clk);
    #1;

    // Directed table: {stimulus, expected num, ovf, match, mismatch}; locked stays 0.
    add("reset", 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
    add_keys("basic_key", 0, 1, 2, 3, 4);
    add("basic_match", 0, 0, 0, 1, 4, 0, 0, 0, 1, 0);
    add("pulse_one_cycle", 0, 0, 0, 0, 4, 0, 0, 0, 0, 0);
    add("short_key", 1, 0, 0, 0, 3, 0, 1, 0, 0, 0);
    add("short_key", 1, 1, 0, 0, 3, 0, 2, 0, 0, 0);
    add("short_cmp", 0, 0, 0, 1, 3, 0, 0, 0, 0, 1);
    add_keys("long_key", 0, 1, 2, 3, 3);
    add("long_cmp", 0, 0, 0, 1, 3, 0, 0, 0, 0, 1);
    add_keys("prio_key", 0, 1, 2, 3, 4);
    add("cmp_with_key", 1, 1, 0, 1, 4, 0, 0, 0, 1, 0);
    add_keys("ovf_key", 0, 1, 2, 3, 4);
    add("ovf_5th", 1, 0, 0, 0, 4, 0, 4, 1, 0, 0);
    add("ovf_cmp", 0, 0, 0, 1, 4, 0, 0, 0, 0, 1);
    add("ovf_cleared", 0, 0, 0, 0, 4, 0, 0, 0, 0, 0);
    add("clr_key", 1, 0, 0, 0, 4, 0, 1, 0, 0, 0);
    add("clr_key", 1, 1, 0, 0, 4, 0, 2, 0, 0, 0);
    add("clr_and_cmp", 0, 0, 1, 1, 4, 0, 0, 0, 0, 0);
    add_keys("bad_digit_key", 0, 1, 3, 3, 4);
    add("bad_digit_cmp", 0, 0, 0, 1, 4, 0, 0, 0, 0, 1);
    add_keys("rematch_key", 0, 1, 2, 3, 4);
    add("rematch_cmp", 0, 0, 0, 1, 4, 0, 0, 0, 1, 0);
    add("plen0_cmp", 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add_keys("plen5_key", 0, 1, 2, 3, 5);
    add("plen5_cmp", 0, 0, 0, 1, 5, 0, 0, 0, 0, 1);
    add_keys("ovf2_key", 1, 1, 1, 1, 4);
    add("ovf2_5th", 1, 2, 0, 0, 4, 0, 4, 1, 0, 0);
    add("clr_ovf", 0, 0, 1, 0, 4, 0, 0, 0, 0, 0);
    add_keys("final_key", 0, 1, 2, 3, 4);
    add("final_match", 0, 0, 0, 1, 4, 0, 0, 0, 1, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].kv, tbl[i].kd, tbl[i].kc, tbl[i].cmp, PW, tbl[i].plen, tbl[i].rst);
      chk(tbl[i].nm, tbl[i].en, tbl[i].eo, tbl[i].em, tbl[i].emm, tbl[i].el);
    end

    // Reset in the middle of an entry drops the pending compare.
    cyc(1, 0, 0, 0, PW, 4, 0);
    cyc(1, 1, 0, 0, PW, 4, 0);
    chk("rst_entry_pre", 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, PW, 2, 1);
    chk("rst_entry", 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, PW, 2, 0);
    chk("rst_entry_after", 0, 0, 0, 0, 0);

`ifdef PASSCODE_LOCKOUT_EN
    // Three wrong compares: locked rises with the third mismatch for LOCK_CYCLES cycles.
    cyc(0, 0, 0, 1, PW, 4, 0);
    chk("lk_fail1", 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, PW, 4, 0);
    chk("lk_fail2", 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, PW, 4, 0);
    chk("lk_fail3", 0, 0, 0, 1, 1);
    for (int c = 1; c <= LOCK_CYCLES; c++) begin
      cyc(c <= 4, c - 1, 0, c == 5, PW, 4, 0);
      chk("lk_hold", 0, 0, 0, 0, c < LOCK_CYCLES);
    end
    for (int i = 0; i < 4; i++) cyc(1, i, 0, 0, PW, 4, 0);
    chk("lk_after_keys", 4, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, PW, 4, 0);
    chk("lk_after_match", 0, 0, 1, 0, 0);

    // Reset during lockout returns straight to entry.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, PW, 4, 0);
    chk("lk2_locked", 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, PW, 4, 0);
    cyc(1, 1, 0, 1, PW, 4, 1);
    chk("lk2_rst", 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, PW, 4, 0);
    chk("lk2_rst_after", 0, 0, 0, 0, 0);
`else
    // Without lockout, repeated mismatches never lock.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, PW, 4, 0);
      chk("nolock_mis", 0, 0, 0, 1, 0);
    end
`endif

    // Randomized traffic checked against the queue model.
    rpw   = PW;
    rplen = 4;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) == 0) rpw = 8'($urandom);
      if ($urandom_range(49) == 0) rplen = $urandom_range(5);
      rst = ($urandom_range(199) == 0);
      kc  = ($urandom_range(24) == 0);
      cmp = ($urandom_range(5) == 0);
      kv  = ($urandom_range(1) == 0);
      if (m_ent.size() < MAX_LEN && $urandom_range(4) != 0)
        kd = pw_digit(rpw, m_ent.size());
      else
        kd = $urandom_range(3);
      cyc(kv, kd, kc, cmp, rpw, rplen, rst);
      chk_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
